rr_arb4: RTL and testbench

Four-requester round-robin arbiter that sequences shared access to one resource. It holds a registered 2-bit winner index and expands it into a one-hot grant vector, using the same code-to-one-hot mapping as the team's 2-to-4 decoder: 00→0001, 01→0010, 10→0100, 11→1000. It sits between up to four client blocks and a single shared datapath or bus. Each grant is held until the owner signals completion, drops its request, or hits a hold-time limit.

---
 rtl/rr_arb4.sv | 160 ++++++++++++++++
 tb/tb_rr_arb4.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arb4.sv
// rr_arb4 - four-requester round-robin arbiter for one shared resource.
//
// The arbiter keeps a registered 2-bit winner index and a one-hot grant
// decoded from it (00->0001, 01->0010, 10->0100, 11->1000). A grant is held
// until the owner raises done, drops its request, or has held the resource
// for HOLD_MAX cycles. On release the next owner is chosen on the same edge,
// so there are no idle cycles between back-to-back owners.
//
// Parameters
//   HOLD_MAX   maximum grant length in cycles, 0 = unlimited (0..255)
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req[3:0]   level-sensitive request vector, bit i = requester i
//   done       current owner finished (ignored while no grant is active)
//   gnt[3:0]   registered one-hot grant, 0000 when no grant
//   gnt_code   registered index of the current owner, holds when idle
//   gnt_valid  a grant is active
//   preempt    one-cycle pulse after a release caused only by timeout
module rr_arb4 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_code,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // With HOLD_MAX = 0 the compare value is meaningless; HOLD_EN masks it.
  localparam logic       HOLD_EN   = (HOLD_MAX != 32'd0);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 32'd1);

  state_t     state_q;
  logic [1:0] last_q;
  logic [7:0] hold_cnt_q;

  logic [1:0] base_s;
  logic [7:0] dbl_s;
  logic [3:0] rot_s;
  logic       found_s;
  logic [1:0] offs_s;
  logic [1:0] win_s;
  logic       owner_req_s;
  logic       timeout_s;
  logic       release_s;

  // 2-to-4 decode of a winner index into the one-hot grant.
  function automatic logic [3:0] dec2to4(input logic [1:0] code);
    logic [3:0] onehot;
    case (code)
      2'b00:   onehot = 4'b0001;
      2'b01:   onehot = 4'b0010;
      2'b10:   onehot = 4'b0100;
      2'b11:   onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

  // Rotating priority search and release detection.
  always_comb begin
    // While granting, the search starts after the current owner (which
    // becomes last on release); while idle it starts after last.
    if (state_q == ST_GRANT) begin
      base_s = gnt_code;
    end else begin
      base_s = last_q;
    end

    // Rotate req so bit k holds requester (base+1+k) mod 4. The base itself
    // lands in bit 3, i.e. it is eligible only after everyone else. An owner
    // released because its own req fell is naturally not eligible.
    dbl_s = {req, req} >> ({1'b0, base_s} + 3'd1);
    rot_s = dbl_s[3:0];

    if (rot_s[0]) begin
      found_s = 1'b1;
      offs_s  = 2'd0;
    end else if (rot_s[1]) begin
      found_s = 1'b1;
      offs_s  = 2'd1;
    end else if (rot_s[2]) begin
      found_s = 1'b1;
      offs_s  = 2'd2;
    end else if (rot_s[3]) begin
      found_s = 1'b1;
      offs_s  = 2'd3;
    end else begin
      found_s = 1'b0;
      offs_s  = 2'd0;
    end

    // 2-bit addition wraps mod 4.
    win_s = base_s + offs_s + 2'd1;

    owner_req_s = req[gnt_code];
    timeout_s   = HOLD_EN && (hold_cnt_q == HOLD_LAST);
    release_s   = done || !owner_req_s || timeout_s;
  end

  // Arbiter FSM with registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= 2'b11;
      hold_cnt_q <= 8'd0;
      gnt        <= 4'b0000;
      gnt_code   <= 2'b00;
      gnt_valid  <= 1'b0;
      preempt    <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          hold_cnt_q <= 8'd0;
          if (found_s) begin
            state_q   <= ST_GRANT;
            gnt_code  <= win_s;
            gnt       <= dec2to4(win_s);
            gnt_valid <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (release_s) begin
            last_q     <= gnt_code;
            hold_cnt_q <= 8'd0;
            // done wins over a coinciding timeout.
            preempt    <= timeout_s && !done && owner_req_s;
            if (found_s) begin
              gnt_code <= win_s;
              gnt      <= dec2to4(win_s);
            end else begin
              state_q   <= ST_IDLE;
              gnt       <= 4'b0000;
              gnt_valid <= 1'b0;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          hold_cnt_q <= 8'd0;
          gnt        <= 4'b0000;
          gnt_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb4.sv
// tb_rr_arb4 - directed and randomized checks of rr_arb4 against a
// behavioural model that tracks owner, last winner and grant age as integers.
module tb_rr_arb4;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_code;
  logic       gnt_valid;
  logic       preempt;

  rr_arb4 #(.HOLD_MAX(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_code  (gnt_code),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit m_valid;
  int m_owner;
  int m_last;
  int m_age;   // grant cycles elapsed including the current one
  bit m_pre;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_owner = 0;
    m_last  = 3;
    m_age   = 0;
    m_pre   = 1'b0;
  endtask

  // First requester after base in circular order; base itself is tried last.
  function automatic int pick(input int base, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic d);
    int w;
    bit to;
    m_pre = 1'b0;
    if (m_valid) begin
      to = (H != 0) && (m_age == H);
      if (d || !r[m_owner] || to) begin
        m_pre  = to && !d && r[m_owner];
        m_last = m_owner;
        w = pick(m_owner, r);
        if (w >= 0) begin
          m_owner = w;
          m_age   = 1;
        end else begin
          m_valid = 1'b0;
          m_age   = 0;
        end
      end else begin
        m_age++;
      end
    end else begin
      w = pick(m_last, r);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_owner = w;
        m_age   = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] e_gnt;
    e_gnt = m_valid ? (4'b0001 << m_owner) : 4'b0000;
    check({tag, "/gnt"},       gnt,                 e_gnt);
    check({tag, "/gnt_code"},  {2'b00, gnt_code},   4'(m_owner));
    check({tag, "/gnt_valid"}, {3'b000, gnt_valid}, {3'b000, m_valid});
    check({tag, "/preempt"},   {3'b000, preempt},   {3'b000, m_pre});
  endtask

  // Drive one cycle of inputs, advance the model, check just after the edge.
  task automatic step(input logic [3:0] r, input logic d, input string tag);
    req  = r;
    done = d;
    model_step(r, d);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b0;
    model_reset();

    // Reset with all requesting: outputs stay cleared.
    #12;
    check_all("reset");
    check("reset_gnt_const", gnt, 4'b0000);
    rst = 1'b0;

    // First grant goes to requester 0, then rotation with done each grant.
    step(4'b1111, 1'b0, "first");
    check("first_gnt", gnt, 4'b0001);
    step(4'b1111, 1'b1, "rot1");
    check("rot1_gnt", gnt, 4'b0010);
    step(4'b1111, 1'b1, "rot2");
    check("rot2_gnt", gnt, 4'b0100);
    step(4'b1111, 1'b1, "rot3");
    check("rot3_gnt", gnt, 4'b1000);
    step(4'b1111, 1'b1, "rot4");
    check("rot4_gnt", gnt, 4'b0001);

    // Skip and wrap: owner 1, req=1001 -> 3, then wrap to 0.
    step(4'b1111, 1'b1, "to_owner1");
    step(4'b1001, 1'b1, "skip");
    check("skip_gnt", gnt, 4'b1000);
    step(4'b1001, 1'b1, "wrap");
    check("wrap_gnt", gnt, 4'b0001);

    // Timeout: owner 0 held exactly H cycles, then preempt with gnt=0010.
    step(4'b0011, 1'b0, "hold1");
    step(4'b0011, 1'b0, "hold2");
    step(4'b0011, 1'b0, "hold3");
    check("hold3_gnt", gnt, 4'b0001);
    step(4'b0011, 1'b0, "timeout");
    check("timeout_gnt", gnt, 4'b0010);
    check("timeout_pre", {3'b000, preempt}, 4'b0001);
    step(4'b0011, 1'b0, "post_to");
    check("post_to_pre", {3'b000, preempt}, 4'b0000);
    step(4'b0011, 1'b0, "hold_b2");
    step(4'b0011, 1'b0, "hold_b3");
    step(4'b0011, 1'b1, "done_and_to");
    check("done_to_gnt", gnt, 4'b0001);
    check("done_to_pre", {3'b000, preempt}, 4'b0000);

    // Drop and idle, done while idle ignored, re-raise.
    step(4'b0000, 1'b0, "drop_all");
    step(4'b0100, 1'b0, "single");
    check("single_gnt", gnt, 4'b0100);
    step(4'b0000, 1'b0, "drop");
    check("drop_valid", {3'b000, gnt_valid}, 4'b0000);
    step(4'b0000, 1'b1, "idle_done");
    step(4'b0100, 1'b0, "reraise");
    check("reraise_gnt", gnt, 4'b0100);

    // Asynchronous reset between edges drops the grant immediately.
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst_gnt", gnt, 4'b0000);
    #2;
    rst = 1'b0;
    step(4'b0100, 1'b0, "after_rst");
    check("after_rst_gnt", gnt, 4'b0100);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
